// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types, limits and helpers for the AXI-Stream TX arbiter
//
// Contents:
//   arb_state_t : arbiter FSM state (ARB_IDLE, ARB_BUSY)
//   MAX_SRC     : largest supported source count
//   src_w(n)    : width of a source index for n sources, never less than 1
package axis_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int MAX_SRC = 8;

    function automatic int src_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// rtl/axis_rr_picker.sv - combinational cyclic priority encoder for round-robin arbitration
//
// Ports:
//   req  : per-source request vector
//   ptr  : index at which the cyclic upward search starts
//   pick : first requester at or after ptr (wrapping), 0 when none
//   any  : high when at least one request is present
module axis_rr_picker
    import axis_arb_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    localparam int SRC_W   = src_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   pick,
    output logic               any
);

    logic [SRC_W-1:0] cand;

    // Walk the offsets from farthest to nearest so the nearest requester
    // (smallest offset from ptr) is the one left in pick at loop exit.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            cand = SRC_W'((int'(ptr) + i) % NUM_SRC);
            if (req[cand]) begin
                pick = cand;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_tx_arbiter.sv
// rtl/axis_tx_arbiter.sv - packet-level round-robin arbiter sharing one AXI-Stream TX path
//
// Optional feature macro: AXIS_ARB_TID_TAG_EN (m_tid carries the source index of each beat;
// without it m_tid is tied to 0).
//
// Ports:
//   ACLK, ARESETn            : clock, asynchronous active-low reset
//   s_tvalid/s_tready/s_tlast: per-source handshake and packet end, one bit per source
//   s_tdata/s_tkeep/s_tuser  : per-source payload, source i in slice i of each bus
//   m_tvalid/m_tready/m_tlast: registered master handshake
//   m_tdata/m_tkeep/m_tuser  : registered master payload
//   m_tid                    : source tag of the presented beat
//   grant                    : index of the current packet owner
//   busy                     : high while a packet is owned
module axis_tx_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int USER_WIDTH = 2,
    parameter  int NUM_SRC    = 4,
    localparam int SRC_W      = src_w(NUM_SRC),
    localparam int KEEP_W     = DATA_WIDTH / 8
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    output logic [NUM_SRC-1:0]            s_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SRC*KEEP_W-1:0]     s_tkeep,
    input  logic [NUM_SRC*USER_WIDTH-1:0] s_tuser,
    input  logic [NUM_SRC-1:0]            s_tlast,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    input  logic                          m_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic [KEEP_W-1:0]             m_tkeep,
    output logic [USER_WIDTH-1:0]         m_tuser,
    output logic [SRC_W-1:0]              m_tid,
    output logic [SRC_W-1:0]              grant,
    output logic                          busy
);

    arb_state_t       state, state_n;
    logic [SRC_W-1:0] grant_q;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] pick;
    logic             any_req;
    logic             out_free;
    logic             accept;
    logic             sel_last;

    axis_rr_picker #(
        .NUM_SRC (NUM_SRC)
    ) u_picker (
        .req  (s_tvalid),
        .ptr  (rr_ptr),
        .pick (pick),
        .any  (any_req)
    );

    // The output register can take a new beat when empty or draining this cycle.
    assign out_free = !m_tvalid || m_tready;
    assign sel_last = s_tlast[grant_q];
    assign accept   = (state == ARB_BUSY) && s_tvalid[grant_q] && out_free;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        s_tready = '0;
        case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    state_n = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                s_tready[grant_q] = out_free;
                if (accept && sel_last) begin
                    state_n = ARB_IDLE;
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    // Grant is only re-chosen in IDLE, so it stays frozen for the whole packet
    // even if the owner stalls.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            grant_q <= '0;
            rr_ptr  <= '0;
        end else begin
            if (state == ARB_IDLE && any_req) begin
                grant_q <= pick;
            end
            if (accept && sel_last) begin
                rr_ptr <= (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + SRC_W'(1);
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tuser  <= '0;
        end else if (accept) begin
            m_tvalid <= 1'b1;
            m_tlast  <= sel_last;
            m_tdata  <= s_tdata[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
            m_tkeep  <= s_tkeep[int'(grant_q) * KEEP_W +: KEEP_W];
            m_tuser  <= s_tuser[int'(grant_q) * USER_WIDTH +: USER_WIDTH];
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

`ifdef AXIS_ARB_TID_TAG_EN
    logic [SRC_W-1:0] tid_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            tid_q <= '0;
        end else if (accept) begin
            tid_q <= grant_q;
        end
    end

    assign m_tid = tid_q;
`else
    assign m_tid = '0;
`endif

    assign grant = grant_q;
    assign busy  = (state == ARB_BUSY);

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// tb/tb_axis_tx_arbiter.sv - directed self-checking bench for axis_tx_arbiter
module tb_axis_tx_arbiter;

`ifdef AXIS_ARB_TID_TAG_EN
    localparam bit TID_EN = 1'b1;
`else
    localparam bit TID_EN = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [3:0]  s_tvalid = '0;
    logic [3:0]  s_tready;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic [7:0]  s_tuser = '0;
    logic [3:0]  s_tlast = '0;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic [15:0] m_tdata;
    logic [1:0]  m_tkeep;
    logic [1:0]  m_tuser;
    logic [1:0]  m_tid;
    logic [1:0]  grant;
    logic        busy;

    int checks = 0;
    int passes = 0;
    logic [15:0] rx_q[$];

    always #5 ACLK = ~ACLK;

    axis_tx_arbiter #(
        .DATA_WIDTH (16),
        .USER_WIDTH (2),
        .NUM_SRC    (4)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tuser  (s_tuser),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tuser  (m_tuser),
        .m_tid    (m_tid),
        .grant    (grant),
        .busy     (busy)
    );

    // Records each master handshake completing at the coming edge, then
    // returns 1 time unit after that edge.
    task automatic tick();
        if (m_tvalid && m_tready) rx_q.push_back(m_tdata);
        @(posedge ACLK);
        #1;
    endtask

    // Source 0 uses keep 2'b01, others 2'b11; tuser is the source index.
    task automatic set_src(input int i, input logic v, input logic [15:0] d, input logic l);
        s_tvalid[i]        = v;
        s_tdata[i*16 +: 16] = d;
        s_tlast[i]         = l;
        s_tkeep[i*2 +: 2]  = (i == 0) ? 2'b01 : 2'b11;
        s_tuser[i*2 +: 2]  = 2'(i);
    endtask

    task automatic do_reset();
        ARESETn  = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        rx_q.delete();
        #3;
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        #12;
        checks++; if (m_tvalid !== 1'b0) $display("FAIL rst_tvalid got %b want 0", m_tvalid); else passes++;
        checks++; if (m_tlast !== 1'b0) $display("FAIL rst_tlast got %b want 0", m_tlast); else passes++;
        checks++; if (m_tdata !== 16'h0) $display("FAIL rst_tdata got %h want 0000", m_tdata); else passes++;
        checks++; if (m_tkeep !== 2'b00) $display("FAIL rst_tkeep got %b want 00", m_tkeep); else passes++;
        checks++; if (m_tuser !== 2'b00) $display("FAIL rst_tuser got %b want 00", m_tuser); else passes++;
        checks++; if (m_tid !== 2'd0) $display("FAIL rst_tid got %0d want 0", m_tid); else passes++;
        checks++; if (grant !== 2'd0) $display("FAIL rst_grant got %0d want 0", grant); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passes++;
        checks++; if (s_tready !== 4'b0000) $display("FAIL rst_sready got %b want 0000", s_tready); else passes++;
    endtask

    task automatic test_single();
        logic [1:0] etid;
        etid = TID_EN ? 2'd2 : 2'd0;
        do_reset();
        set_src(2, 1'b1, 16'h1111, 1'b0);
        tick();
        checks++; if (grant !== 2'd2) $display("FAIL sgl_grant got %0d want 2", grant); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL sgl_busy got %b want 1", busy); else passes++;
        checks++; if (m_tvalid !== 1'b0) $display("FAIL sgl_tvalid0 got %b want 0", m_tvalid); else passes++;
        checks++; if (s_tready !== 4'b0100) $display("FAIL sgl_sready got %b want 0100", s_tready); else passes++;
        tick();
        checks++; if (m_tvalid !== 1'b1 || m_tdata !== 16'h1111 || m_tlast !== 1'b0)
            $display("FAIL sgl_beat1 got v=%b d=%h l=%b want v=1 d=1111 l=0", m_tvalid, m_tdata, m_tlast); else passes++;
        checks++; if (m_tuser !== 2'd2 || m_tkeep !== 2'b11 || m_tid !== etid)
            $display("FAIL sgl_side got u=%0d k=%b id=%0d want u=2 k=11 id=%0d", m_tuser, m_tkeep, m_tid, etid); else passes++;
        set_src(2, 1'b1, 16'h2222, 1'b0);
        tick();
        checks++; if (m_tdata !== 16'h2222 || m_tlast !== 1'b0 || busy !== 1'b1)
            $display("FAIL sgl_beat2 got d=%h l=%b b=%b want d=2222 l=0 b=1", m_tdata, m_tlast, busy); else passes++;
        set_src(2, 1'b1, 16'h3333, 1'b1);
        tick();
        checks++; if (m_tdata !== 16'h3333 || m_tlast !== 1'b1 || busy !== 1'b0)
            $display("FAIL sgl_beat3 got d=%h l=%b b=%b want d=3333 l=1 b=0", m_tdata, m_tlast, busy); else passes++;
        checks++; if (s_tready !== 4'b0000) $display("FAIL sgl_sready_idle got %b want 0000", s_tready); else passes++;
        set_src(2, 1'b0, 16'h0000, 1'b0);
        tick();
        checks++; if (m_tvalid !== 1'b0) $display("FAIL sgl_drain got %b want 0", m_tvalid); else passes++;
    endtask

    task automatic test_fairness();
        int exp;
        logic [1:0] etid;
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, 1'b1, 16'(16'hA000 + i), 1'b1);
        for (int k = 0; k < 5; k++) begin
            exp  = k % 4;
            etid = TID_EN ? 2'(exp) : 2'd0;
            tick();
            checks++; if (grant !== 2'(exp) || busy !== 1'b1)
                $display("FAIL rr_grant%0d got g=%0d b=%b want g=%0d b=1", k, grant, busy, exp); else passes++;
            checks++; if (s_tready !== 4'(1 << exp))
                $display("FAIL rr_sready%0d got %b want %b", k, s_tready, 4'(1 << exp)); else passes++;
            tick();
            checks++; if (m_tvalid !== 1'b1 || m_tdata !== 16'(16'hA000 + exp) || m_tlast !== 1'b1)
                $display("FAIL rr_data%0d got v=%b d=%h l=%b want v=1 d=%h l=1", k, m_tvalid, m_tdata, m_tlast, 16'(16'hA000 + exp)); else passes++;
            checks++; if (m_tid !== etid || busy !== 1'b0)
                $display("FAIL rr_tid%0d got id=%0d b=%b want id=%0d b=0", k, m_tid, busy, etid); else passes++;
        end
        s_tvalid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_src(1, 1'b1, 16'hB001, 1'b0);
        tick();
        tick();
        checks++; if (m_tdata !== 16'hB001 || m_tvalid !== 1'b1)
            $display("FAIL bp_first got d=%h v=%b want d=B001 v=1", m_tdata, m_tvalid); else passes++;
        set_src(1, 1'b1, 16'hB002, 1'b0);
        m_tready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (m_tvalid !== 1'b1 || m_tdata !== 16'hB001 || m_tlast !== 1'b0 || m_tkeep !== 2'b11)
                $display("FAIL bp_hold%0d got v=%b d=%h l=%b k=%b want v=1 d=B001 l=0 k=11", c, m_tvalid, m_tdata, m_tlast, m_tkeep); else passes++;
            checks++; if (s_tready[1] !== 1'b0)
                $display("FAIL bp_sready%0d got %b want 0", c, s_tready[1]); else passes++;
        end
        m_tready = 1'b1;
        tick();
        set_src(1, 1'b1, 16'hB003, 1'b0);
        tick();
        set_src(1, 1'b1, 16'hB004, 1'b1);
        tick();
        set_src(1, 1'b0, 16'h0000, 1'b0);
        tick();
        checks++; if (rx_q.size() !== 4) $display("FAIL bp_count got %0d want 4", rx_q.size()); else passes++;
        if (rx_q.size() == 4) begin
            for (int b = 0; b < 4; b++) begin
                checks++; if (rx_q[b] !== 16'(16'hB001 + b))
                    $display("FAIL bp_beat%0d got %h want %h", b, rx_q[b], 16'(16'hB001 + b)); else passes++;
            end
        end
    endtask

    task automatic test_no_interleave();
        logic [1:0] etid;
        etid = TID_EN ? 2'd0 : 2'd0;
        do_reset();
        set_src(1, 1'b1, 16'hC001, 1'b0);
        tick();
        tick();
        set_src(0, 1'b1, 16'hD000, 1'b1);
        for (int b = 2; b <= 5; b++) begin
            set_src(1, 1'b1, 16'(16'hC000 + b), (b == 5));
            tick();
            checks++; if (m_tdata !== 16'(16'hC000 + b) || grant !== 2'd1 || s_tready[0] !== 1'b0)
                $display("FAIL ni_beat%0d got d=%h g=%0d r0=%b want d=%h g=1 r0=0", b, m_tdata, grant, s_tready[0], 16'(16'hC000 + b)); else passes++;
        end
        checks++; if (m_tlast !== 1'b1 || busy !== 1'b0)
            $display("FAIL ni_end got l=%b b=%b want l=1 b=0", m_tlast, busy); else passes++;
        set_src(1, 1'b0, 16'h0000, 1'b0);
        tick();
        checks++; if (grant !== 2'd0 || busy !== 1'b1)
            $display("FAIL ni_grant0 got g=%0d b=%b want g=0 b=1", grant, busy); else passes++;
        tick();
        checks++; if (m_tdata !== 16'hD000 || m_tlast !== 1'b1 || m_tkeep !== 2'b01 || m_tid !== etid)
            $display("FAIL ni_src0 got d=%h l=%b k=%b id=%0d want d=D000 l=1 k=01 id=%0d", m_tdata, m_tlast, m_tkeep, m_tid, etid); else passes++;
        s_tvalid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_src(2, 1'b1, 16'hE002, 1'b1);
        tick();
        tick();
        set_src(2, 1'b0, 16'h0000, 1'b0);
        set_src(3, 1'b1, 16'hF001, 1'b0);
        tick();
        checks++; if (grant !== 2'd3) $display("FAIL rm_grant3 got %0d want 3", grant); else passes++;
        tick();
        set_src(3, 1'b1, 16'hF002, 1'b0);
        tick();
        checks++; if (m_tdata !== 16'hF002 || busy !== 1'b1)
            $display("FAIL rm_second got d=%h b=%b want d=F002 b=1", m_tdata, busy); else passes++;
        #2;
        ARESETn = 1'b0;
        #1;
        checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 16'h0 || m_tkeep !== 2'b00 || m_tuser !== 2'b00)
            $display("FAIL rm_mout got v=%b l=%b d=%h k=%b u=%b want all 0", m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser); else passes++;
        checks++; if (grant !== 2'd0 || busy !== 1'b0 || s_tready !== 4'b0000 || m_tid !== 2'd0)
            $display("FAIL rm_ctrl got g=%0d b=%b r=%b id=%0d want g=0 b=0 r=0000 id=0", grant, busy, s_tready, m_tid); else passes++;
        set_src(3, 1'b1, 16'hF101, 1'b1);
        set_src(1, 1'b1, 16'h1101, 1'b1);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
        checks++; if (grant !== 2'd1 || busy !== 1'b1)
            $display("FAIL rm_ptr0 got g=%0d b=%b want g=1 b=1", grant, busy); else passes++;
        tick();
        checks++; if (m_tdata !== 16'h1101 || m_tlast !== 1'b1)
            $display("FAIL rm_src1 got d=%h l=%b want d=1101 l=1", m_tdata, m_tlast); else passes++;
        set_src(1, 1'b0, 16'h0000, 1'b0);
        tick();
        checks++; if (grant !== 2'd3) $display("FAIL rm_regrant got %0d want 3", grant); else passes++;
        tick();
        checks++; if (m_tdata !== 16'hF101 || m_tlast !== 1'b1 || m_tuser !== 2'd3)
            $display("FAIL rm_src3 got d=%h l=%b u=%0d want d=F101 l=1 u=3", m_tdata, m_tlast, m_tuser); else passes++;
        s_tvalid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_no_interleave();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/axis_tx_arbiter.md
# axis_tx_arbiter

Packet-level round-robin arbiter that shares one AXI-Stream transmit path between `NUM_SRC` AXI-Stream sources in the SHA3 streaming datapath. A grant is held from a packet's first beat until its TLAST beat is accepted, so packets are never interleaved. Output is a single registered stage: timing is isolated from the downstream transmitter and sink, and back-pressure is honoured.

## Interface
- `DATA_WIDTH`, 16: TDATA width in bits; a multiple of 8.
- `USER_WIDTH`, 2: TUSER width in bits.
- `NUM_SRC`, 4: number of sources, 2..8; `SRC_W = $clog2(NUM_SRC)`.

Ports:
- `ACLK` in 1: clock; all logic is rising-edge.
- `ARESETn` in 1: asynchronous, active-low reset.
- `s_tvalid` in `NUM_SRC`: per-source TVALID.
- `s_tready` out `NUM_SRC`: per-source TREADY.
- `s_tdata` in `NUM_SRC*DATA_WIDTH`: source *i* occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_tkeep` in `NUM_SRC*DATA_WIDTH/8`: per-source TKEEP, packed the same way.
- `s_tuser` in `NUM_SRC*USER_WIDTH`: per-source TUSER.
- `s_tlast` in `NUM_SRC`: per-source TLAST.
- `m_tvalid`, `m_tlast` out 1: master stream.
- `m_tready` in 1: master TREADY.
- `m_tdata` out `DATA_WIDTH`.
- `m_tkeep` out `DATA_WIDTH/8`.
- `m_tuser` out `USER_WIDTH`.
- `m_tid` out `SRC_W`: source tag (see Configuration).
- `grant` out `SRC_W`: index of the current owner.
- `busy` out 1: high while a packet is owned.

## Operation
- The FSM has two states, IDLE and BUSY.
- **IDLE:** all `s_tready` are 0.
  - If any `s_tvalid` is 1, pick the first requester at or after `rr_ptr`, searching cyclically upward.
  - At the next edge: register `grant`, set `busy=1`, go to BUSY.
- **BUSY:**
  - `s_tready[grant] = !m_tvalid || m_tready`; every other `s_tready` is 0.
  - An accepted beat loads `m_tdata`, `m_tkeep`, `m_tuser` and `m_tlast` from the granted source, and sets `m_tvalid=1`.
  - `m_tvalid` clears when `m_tready=1` and no new beat is loaded in the same cycle.
- **End of packet:** when a beat with `s_tlast=1` is accepted, at the same edge go to IDLE, set `busy=0` and `rr_ptr = (grant+1) mod NUM_SRC`.
  - That last beat still drains from the output register normally.
- **Stalled owner:** if the owner drops `s_tvalid` mid-packet, the grant is held indefinitely. There is no timeout and no pre-emption.
- **Simultaneous requests:** round-robin order guarantees every requester is served within `NUM_SRC` packets.
- **Reset mid-packet:** all state is cleared immediately. The partial packet is truncated (no TLAST is emitted), and `rr_ptr` returns to 0.
- **Reset values:** `m_tvalid=0`, `m_tlast=0`, `m_tdata=0`, `m_tkeep=0`, `m_tuser=0`, `m_tid=0`, `grant=0`, `busy=0`, `s_tready=0`, `rr_ptr=0`, state IDLE.

## Timing
- **Arbitration latency:** a request seen in IDLE at edge *n* gives `busy=1` after edge *n*. The first beat can be accepted at edge *n+1* and appears on `m_*` after that edge.
- **Datapath latency:** exactly 1 cycle from source acceptance to master presentation.
- **Throughput:** 1 beat/cycle within a packet while `m_tready=1`.
- **Packet gap:** exactly one IDLE cycle at the source side between consecutive packets.
- **Master handshake:** while `m_tvalid=1 && m_tready=0`, all `m_*` outputs are held stable.
- **Single-beat packets:** a packet whose first beat carries `s_tlast=1` is legal and takes 2 cycles per packet (arbitrate + transfer).

## Configuration
- `AXIS_ARB_TID_TAG_EN` defined: `m_tid` is loaded with `grant` on every accepted beat, so the sink can demultiplex by source.
- Undefined: `m_tid` is tied to 0 and no tag register is built.
- `grant` and `busy` are present in both builds.

## Structure
- Shared package `axis_arb_pkg` holds:
  - the state enum `arb_state_t {ARB_IDLE, ARB_BUSY}`;
  - `localparam int MAX_SRC = 8`;
  - the function `src_w(n)` returning `$clog2(n)`, with a minimum of 1.
- Sub-module `axis_rr_picker`: combinational cyclic priority encoder.
  - Inputs: `req[NUM_SRC]`, `ptr`.
  - Outputs: `pick`, `any`.
- The top level holds the FSM, `rr_ptr`, the output register and the ready logic.

## Test plan
- **Single source:** source 2 sends a 3-beat packet (0x1111, 0x2222, 0x3333 with TLAST), `m_tready=1`.
  - `grant=2`.
  - `m_tdata` shows the three beats on consecutive cycles.
  - `m_tlast` is high on 0x3333 only; `busy` drops after the third acceptance.
- **Round-robin fairness:** all 4 sources request 1-beat packets continuously from reset.
  - Grant order is 0,1,2,3,0.
  - `m_tid` (with the macro defined) matches the grant order.
- **Back-pressure:** during a 4-beat packet, `m_tready=0` for 3 cycles mid-packet.
  - `m_*` are held stable and `s_tready[grant]=0`.
  - No beat is lost or duplicated; the output is the 4 beats in order.
- **No interleave:** source 1 starts a 5-beat packet and source 0 raises `s_tvalid` on its second beat.
  - Source 0 is not granted until source 1's TLAST beat is accepted.
  - Then `grant=0` (the next requester at or after `rr_ptr=2`, wrapping).
- **Reset mid-packet:** assert `ARESETn=0` asynchronously on the second beat of a 4-beat packet.
  - All outputs go to their reset values without waiting for a clock edge.
  - After release, a new packet from source 3 is granted cleanly, starting the search from `rr_ptr=0`.
- **Macro off:** build without `AXIS_ARB_TID_TAG_EN` and repeat the fairness test.
  - `m_tid` is constantly 0.
  - All other outputs are identical to the macro-on build.
